// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall sequencer.
//   ctrl_state_e : sequencer state (RUN, FLUSH, ERROR)
//   NOP_INSTR    : instruction encoding loaded into a flushed pipeline register
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    ERROR = 2'd2
  } ctrl_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
//   clk   : clock
//   rst_n : asynchronous active-low reset (clears q)
//   inc   : increment request for this cycle
//   q     : current count
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core.
// Inputs : ID source registers and their use flags, EX rd / load / taken-branch, IM/DM busy.
// Outputs: pipeline register enables (PC, IF/ID, EX/MEM, MEM/WB), IF/ID and ID/EX flushes,
//          sticky memory-stall watchdog flag, saturating stall and redirect counters.
// Control outputs are combinational in state and inputs; everything else is registered.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned FLUSH_EXTRA = 1,
  parameter int unsigned MAX_WAIT    = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] ID_rs1_addr,
  input  logic [REG_AW-1:0] ID_rs2_addr,
  input  logic              ID_rs1_used,
  input  logic              ID_rs2_used,
  input  logic [REG_AW-1:0] EX_rd_addr,
  input  logic              EX_MemRead,
  input  logic              EX_BranchTaken,
  input  logic              IM_stall,
  input  logic              DM_stall,
  output logic              PC_Write,
  output logic              IF_ID_Write,
  output logic              IF_ID_Flush,
  output logic              ID_EX_Flush,
  output logic              EX_MEM_Write,
  output logic              MEM_WB_Write,
  output logic              wait_timeout,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  redirect_cnt
);

  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

  ctrl_state_e      state;
  logic [1:0]       extra_cnt;
  logic [WaitW-1:0] wait_cnt;

  logic mem_busy;
  logic load_use;
  logic pc_wr, ifid_wr, ifid_fl, idex_fl, exmem_wr, memwb_wr;

  assign mem_busy = IM_stall | DM_stall;
  assign load_use = EX_MemRead && (EX_rd_addr != '0) &&
                    ((ID_rs1_used && (ID_rs1_addr == EX_rd_addr)) ||
                     (ID_rs2_used && (ID_rs2_addr == EX_rd_addr)));

  // Priority: error/mem_busy > taken branch > pending extra flush > load-use.
  always_comb begin
    pc_wr    = 1'b1;
    ifid_wr  = 1'b1;
    ifid_fl  = 1'b0;
    idex_fl  = 1'b0;
    exmem_wr = 1'b1;
    memwb_wr = 1'b1;
    if ((state == ERROR) || mem_busy) begin
      pc_wr    = 1'b0;
      ifid_wr  = 1'b0;
      exmem_wr = 1'b0;
      memwb_wr = 1'b0;
    end else if (EX_BranchTaken) begin
      ifid_fl = 1'b1;
      idex_fl = 1'b1;
    end else if (state == FLUSH) begin
      // ID holds a wrong-path bubble, so load-use is irrelevant here
      ifid_fl = 1'b1;
    end else if (load_use) begin
      pc_wr   = 1'b0;
      ifid_wr = 1'b0;
      idex_fl = 1'b1;
    end
  end

  // Held low for the whole reset window, not just until the first edge.
  assign PC_Write     = rst_n & pc_wr;
  assign IF_ID_Write  = rst_n & ifid_wr;
  assign IF_ID_Flush  = rst_n & ifid_fl;
  assign ID_EX_Flush  = rst_n & idex_fl;
  assign EX_MEM_Write = rst_n & exmem_wr;
  assign MEM_WB_Write = rst_n & memwb_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      extra_cnt    <= '0;
      wait_cnt     <= '0;
      wait_timeout <= 1'b0;
    end else if (state != ERROR) begin
      if (mem_busy) begin
        wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt == WaitW'(MAX_WAIT - 1)) begin
          wait_timeout <= 1'b1;
          state        <= ERROR;
        end
      end else begin
        wait_cnt <= '0;
        if (EX_BranchTaken) begin
          if (FLUSH_EXTRA > 0) begin
            extra_cnt <= 2'(FLUSH_EXTRA);
            state     <= FLUSH;
          end
        end else if (state == FLUSH) begin
          extra_cnt <= extra_cnt - 1'b1;
          if (extra_cnt == 2'd1) begin
            state <= RUN;
          end
        end
      end
    end
  end

  logic stall_inc;
  logic redirect_inc;

  assign stall_inc    = (state != ERROR) && !pc_wr;
  assign redirect_inc = (state != ERROR) && !mem_busy && EX_BranchTaken;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .q     (stall_cnt)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_redirect_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (redirect_inc),
    .q     (redirect_cnt)
  );

endmodule
